// File: rtl/pr_arbiter.sv
// pr_arbiter: round-robin merge of two packet-request streams into one,
// buffered by a 2-entry FIFO so input acceptance never looks at the
// downstream ready.
//
// Handshake (all three ports): a transfer happens on a rising CLK edge where
// VALID && READY. A sender holds VALID and DATA stable until that edge. The
// input READYs depend only on reset, FIFO occupancy, the priority bit and the
// *other* input's VALID. They never depend on their own VALID or on
// SEND_PR_READY.
module pr_arbiter #(
    parameter int PACKET_REQUEST_WIDTH = 32
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            RECEIVE_PR0_VALID,
    input  logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR0_DATA,
    output logic                            RECEIVE_PR0_READY,
    input  logic                            RECEIVE_PR1_VALID,
    input  logic [PACKET_REQUEST_WIDTH-1:0] RECEIVE_PR1_DATA,
    output logic                            RECEIVE_PR1_READY,
    output logic                            SEND_PR_VALID,
    output logic [PACKET_REQUEST_WIDTH-1:0] SEND_PR_DATA,
    input  logic                            SEND_PR_READY
);

    logic [1:0]                      count;
    logic                            head;
    logic                            tail;
    logic                            pri;
    logic [PACKET_REQUEST_WIDTH-1:0] mem [2];

    logic                            not_full;
    logic                            push0;
    logic                            push1;
    logic                            push;
    logic                            pop;
    logic [PACKET_REQUEST_WIDTH-1:0] push_data;

    // Grant: an input is blocked only when the FIFO is full, during reset, or
    // when the other input is requesting and holds priority. Full is judged on
    // the registered count alone, so a pop in the same cycle does not reopen
    // the inputs (one bubble after full).
    always_comb begin
        not_full          = (count != 2'd2);
        RECEIVE_PR0_READY = !RST && not_full && (!pri || !RECEIVE_PR1_VALID);
        RECEIVE_PR1_READY = !RST && not_full && ( pri || !RECEIVE_PR0_VALID);
        push0             = RECEIVE_PR0_VALID && RECEIVE_PR0_READY;
        push1             = RECEIVE_PR1_VALID && RECEIVE_PR1_READY;
        push              = push0 || push1;
        push_data         = push0 ? RECEIVE_PR0_DATA : RECEIVE_PR1_DATA;
        pop               = SEND_PR_VALID && SEND_PR_READY;
    end

    // Output side: head entry straight out of the payload registers.
    always_comb begin
        SEND_PR_VALID = (count != 2'd0);
        SEND_PR_DATA  = mem[head];
    end

    // Control state: occupancy, pointers and round-robin priority. Priority
    // moves to the other input after every push, contested or not.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
            pri   <= 1'b0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                tail <= ~tail;
                pri  <= push0;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

    // Payload registers: written at tail on push. A push can only happen with
    // count < 2, so when it overlaps a pop (count == 1) tail != head and the
    // entry being read is never overwritten.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

endmodule
